// File: rtl/rmii_rx_if.sv
// Received byte stream from the RMII receive path to the frame parser.
// The master side drives the stream; the slave side consumes it.
interface rmii_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_err;
    logic       fcs_err;

    modport master (output rx_data, rx_valid, rx_sof, rx_eof, rx_err, fcs_err);
    modport slave  (input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, fcs_err);
endinterface

// File: rtl/rmii_rx.sv
// RMII receive path: preamble/SFD strip, dibit-to-byte packing, sof/eof/err framing.
// Define RMII_RX_FCS_CHECK_EN to enable the CRC-32 residue check on fcs_err.
module rmii_rx #(
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1522,
    parameter int CNT_W     = 11
) (
    input  logic     clk_50MHz,
    input  logic     rst,
    input  logic     CRS,
    input  logic     RX0,
    input  logic     RX1,
    rmii_rx_if.master rx
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] ABORT    = 3'd3;
    localparam logic [2:0] DROP     = 3'd4;

    logic [2:0]       state;
    logic [1:0]       d;
    logic             crs, crs_prev;
    logic [5:0]       sr;
    logic [7:0]       hold;
    logic             hold_full, first;
    logic [1:0]       dcnt;
    logic [CNT_W-1:0] bcnt;
    logic [7:0]       byte_nxt;
    logic [CNT_W-1:0] bcnt_nxt;
    logic             fcs_bad;

    assign byte_nxt = {d, sr};
    assign bcnt_nxt = bcnt + 1'b1;

`ifdef RMII_RX_FCS_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Reflected register form: DEBB20E3 is C704DD7B bit-reversed.
    assign fcs_bad = (crc != 32'hDEBB20E3);

    always_ff @(posedge clk_50MHz) begin
        if (rst)
            crc <= 32'hFFFFFFFF;
        else if (state == PREAMBLE && crs && d == 2'b11)
            crc <= 32'hFFFFFFFF;
        else if (state == DATA && crs && dcnt == 2'd3)
            crc <= crc_byte(crc, byte_nxt);
    end
`else
    assign fcs_bad = 1'b0;
`endif

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state       <= IDLE;
            d           <= 2'b00;
            // Treat the line as already busy so a frame in flight is never joined mid-way.
            crs         <= 1'b1;
            crs_prev    <= 1'b1;
            sr          <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            first       <= 1'b0;
            dcnt        <= '0;
            bcnt        <= '0;
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            rx.rx_sof   <= 1'b0;
            rx.rx_eof   <= 1'b0;
            rx.rx_err   <= 1'b0;
            rx.fcs_err  <= 1'b0;
        end else begin
            d           <= {RX1, RX0};
            crs         <= CRS;
            crs_prev    <= crs;
            rx.rx_valid <= 1'b0;
            rx.rx_sof   <= 1'b0;
            rx.rx_eof   <= 1'b0;
            rx.rx_err   <= 1'b0;
            rx.fcs_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (crs && !crs_prev && d == 2'b01)
                        state <= PREAMBLE;
                end
                PREAMBLE: begin
                    if (!crs)
                        state <= IDLE;
                    else if (d == 2'b11) begin
                        state     <= DATA;
                        dcnt      <= '0;
                        bcnt      <= '0;
                        hold_full <= 1'b0;
                        first     <= 1'b1;
                    end else if (d != 2'b01)
                        state <= DROP;
                end
                DATA: begin
                    if (!crs) begin
                        if (hold_full) begin
                            rx.rx_valid <= 1'b1;
                            rx.rx_data  <= hold;
                            rx.rx_sof   <= first;
                            rx.rx_eof   <= 1'b1;
                            rx.rx_err   <= (dcnt != 2'd0) || (bcnt < CNT_W'(MIN_BYTES));
                            rx.fcs_err  <= fcs_bad;
                        end
                        hold_full <= 1'b0;
                        first     <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        sr   <= byte_nxt[7:2];
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == 2'd3) begin
                            // One byte of hold so the last byte can carry eof.
                            if (hold_full) begin
                                rx.rx_valid <= 1'b1;
                                rx.rx_data  <= hold;
                                rx.rx_sof   <= first;
                                first       <= 1'b0;
                            end
                            hold      <= byte_nxt;
                            hold_full <= 1'b1;
                            bcnt      <= bcnt_nxt;
                            if (bcnt_nxt == CNT_W'(MAX_BYTES + 1))
                                state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    rx.rx_valid <= 1'b1;
                    rx.rx_data  <= hold;
                    rx.rx_sof   <= first;
                    rx.rx_eof   <= 1'b1;
                    rx.rx_err   <= 1'b1;
                    rx.fcs_err  <= fcs_bad;
                    hold_full   <= 1'b0;
                    first       <= 1'b0;
                    state       <= crs ? DROP : IDLE;
                end
                DROP: begin
                    if (!crs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rmii_rx.sv
// Directed bench for rmii_rx: frames driven as RMII dibits, byte strobes logged and
// compared against hand-built frames.
module tb_rmii_rx;
    logic clk_50MHz = 1'b0;
    logic rst = 1'b1;
    logic CRS = 1'b0, RX0 = 1'b0, RX1 = 1'b0;

    rmii_rx_if bus ();

    rmii_rx dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .CRS       (CRS),
        .RX0       (RX0),
        .RX1       (RX1),
        .rx        (bus)
    );

    always #10 clk_50MHz = ~clk_50MHz;

`ifdef RMII_RX_FCS_CHECK_EN
    localparam logic FLIP_FCS = 1'b1;
`else
    localparam logic FLIP_FCS = 1'b0;
`endif

    typedef struct packed {
        logic       fcs;
        logic       err;
        logic       eof;
        logic       sof;
        logic [7:0] data;
    } strobe_t;

    strobe_t    q[$];
    logic [7:0] frame [0:1599];
    int         n_checks = 0;
    int         n_errors = 0;

    always @(negedge clk_50MHz)
        if (bus.rx_valid === 1'b1)
            q.push_back({bus.fcs_err, bus.rx_err, bus.rx_eof, bus.rx_sof, bus.rx_data});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dibit(input logic [1:0] v);
        @(negedge clk_50MHz);
        CRS = 1'b1;
        RX0 = v[0];
        RX1 = v[1];
    endtask

    task automatic tx_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) dibit(b[2*i +: 2]);
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk_50MHz);
            CRS = 1'b0;
            RX0 = 1'b0;
            RX1 = 1'b0;
        end
    endtask

    task automatic preamble();
        repeat (7) tx_byte(8'h55);
        tx_byte(8'hD5);
    endtask

    task automatic tx_frame(input int len);
        preamble();
        for (int i = 0; i < len; i++) tx_byte(frame[i]);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // 60 payload bytes 00..3B followed by the FCS (complemented CRC, low byte first).
    task automatic build_good();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            frame[i] = i[7:0];
            c = crc_upd(c, frame[i]);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frame[60+i] = c[8*i +: 8];
    endtask

    task automatic check_frame(input string tag, input int n, input logic err,
                               input logic fcs, input bit use_fcs);
        int bad, sofs, eofs, m;
        chk({tag, "_count"}, q.size(), n);
        if (n > 0 && q.size() > 0) begin
            m = (q.size() < n) ? q.size() : n;
            bad = 0; sofs = 0; eofs = 0;
            for (int i = 0; i < q.size(); i++) begin
                if (i < m && q[i].data !== frame[i]) bad++;
                if (q[i].sof) sofs++;
                if (q[i].eof) eofs++;
            end
            chk({tag, "_data"}, bad, 0);
            chk({tag, "_sof_first"}, q[0].sof, 1);
            chk({tag, "_sof_count"}, sofs, 1);
            chk({tag, "_eof_count"}, eofs, 1);
            chk({tag, "_eof_last"}, q[q.size()-1].eof, 1);
            chk({tag, "_err"}, q[q.size()-1].err, err);
            if (use_fcs) chk({tag, "_fcs"}, q[q.size()-1].fcs, fcs);
        end
        q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk_50MHz);
        chk("reset_out", {bus.rx_data, bus.rx_valid, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.fcs_err}, 0);
        rst = 1'b0;
        quiet(5);

        build_good();
        tx_frame(64); quiet(10);
        check_frame("good", 64, 1'b0, 1'b0, 1'b1);

        build_good();
        frame[10] = 8'hFF;
        tx_frame(64); quiet(10);
        check_frame("flip", 64, 1'b0, FLIP_FCS, 1'b1);

        for (int i = 0; i < 20; i++) frame[i] = 8'h40 + i[7:0];
        tx_frame(20); quiet(10);
        check_frame("short", 20, 1'b1, 1'b0, 1'b0);

        build_good();
        tx_frame(64); dibit(2'b10); quiet(10);
        check_frame("tail", 64, 1'b1, 1'b0, 1'b0);

        tx_byte(8'h55); tx_byte(8'h55); tx_byte(8'h57); quiet(10);
        check_frame("pre57", 0, 1'b0, 1'b0, 1'b0);

        tx_byte(8'h55); tx_byte(8'h56);
        for (int i = 0; i < 20; i++) tx_byte(i[7:0]);
        quiet(10);
        check_frame("pre56", 0, 1'b0, 1'b0, 1'b0);

        build_good();
        tx_frame(64); quiet(10);
        check_frame("after_drop", 64, 1'b0, 1'b0, 1'b1);

        // Reset held across byte 30 while the frame keeps arriving.
        build_good();
        preamble();
        for (int i = 0; i < 30; i++) tx_byte(frame[i]);
        rst = 1'b1;
        dibit(frame[30][1:0]);
        q.delete();
        dibit(frame[30][3:2]); dibit(frame[30][5:4]); dibit(frame[30][7:6]);
        chk("rst_out", {bus.rx_data, bus.rx_valid, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.fcs_err}, 0);
        rst = 1'b0;
        for (int i = 31; i < 64; i++) tx_byte(frame[i]);
        quiet(10);
        check_frame("rst_abort", 0, 1'b0, 1'b0, 1'b0);

        build_good();
        tx_frame(64); quiet(10);
        check_frame("rst_next", 64, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 1600; i++) frame[i] = i[7:0];
        tx_frame(1600); quiet(10);
        check_frame("long", 1523, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
